// File: rtl/spram_req_ctrl.sv
// spram_req_ctrl: turns a valid/ready request stream into single-port RAM
// accesses, returns read data on a valid/ready response channel and runs a
// one-location-per-cycle clear of the whole RAM on request.
module spram_req_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    // clear control
    input  logic                  clr_start,
    output logic                  clr_busy,
    // RAM port
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_rdn_wr,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_CLEAR
    } state_e;

    // One extra bit so the step past the last address is visible as a carry
    // instead of wrapping back to zero.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_data_in_q, ram_data_in_d;
    logic                    ram_rdn_wr_q, ram_rdn_wr_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    clr_pending_q, clr_pending_d;
    logic [CNT_W-1:0]        clr_cnt_q, clr_cnt_d;

    logic                    req_fire;
    logic [CNT_W-1:0]        clr_cnt_inc;

    // Ready is a pure function of state and the clear pulse, never of
    // req_valid; a pending or arriving clear blocks new requests.
    assign req_ready   = rst_n & (state_q == ST_IDLE) & ~rsp_valid_q
                       & ~clr_pending_q & ~clr_start;
    assign req_fire    = req_valid & req_ready;
    assign clr_cnt_inc = clr_cnt_q + CNT_ONE;

    assign clr_busy    = clr_pending_q | (state_q == ST_CLEAR);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_rdn_wr  = ram_rdn_wr_q;

    // Next-state and next-output logic for the access/clear sequencer.
    always_comb begin
        // NOTE: every _d starts at its held value so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_rdn_wr_d  = ram_rdn_wr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        clr_cnt_d     = clr_cnt_q;

        // A clear request is remembered until serviced; pulses that arrive
        // while a clear is already running do not re-arm it.
        clr_pending_d = clr_pending_q | (clr_start & (state_q != ST_CLEAR));

        // Consumer handshake retires the held response.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_pending_q && !rsp_valid_q) begin
                    state_d       = ST_CLEAR;
                    clr_cnt_d     = '0;
                    ram_addr_d    = '0;
                    ram_data_in_d = '0;
                    ram_rdn_wr_d  = 1'b1;
                end else if (req_fire) begin
                    state_d       = ST_ACCESS;
                    ram_addr_d    = req_addr;
                    ram_rdn_wr_d  = req_wr;
                    ram_data_in_d = req_wr ? req_wdata : '0;
                end
            end

            ST_ACCESS: begin
                // The RAM samples the operation at this edge.
                ram_rdn_wr_d = 1'b0;
                state_d      = ram_rdn_wr_q ? ST_IDLE : ST_CAPTURE;
            end

            ST_CAPTURE: begin
                rsp_rdata_d = ram_data_out;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end

            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_inc;
                if (clr_cnt_inc[ADDR_WIDTH]) begin
                    // Last address has just been written; ram_addr holds it.
                    ram_rdn_wr_d  = 1'b0;
                    clr_pending_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    ram_addr_d = clr_cnt_inc[ADDR_WIDTH-1:0];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset also aborts any RAM write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_rdn_wr_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            clr_pending_q <= 1'b0;
            clr_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values,
            // independent of statement order.
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_rdn_wr_q  <= ram_rdn_wr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            clr_pending_q <= clr_pending_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

endmodule

// File: doc/spram_req_ctrl.md
Name: spram_req_ctrl

Overview:
- Upstream request controller for the single-port RAM; its outputs drive the RAM port signals (addr, data_in, rdn_wr), and it consumes the RAM's data_out.
- Converts a valid/ready request stream into correctly timed RAM accesses.
- Returns read data on a valid/ready response channel.
- Provides a sequenced clear-all-memory operation.

Parameters:
- ADDR_WIDTH, 16, RAM address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes the read data.
- rsp_rdata  output  DATA_WIDTH  read data.
- clr_start  input  1  single-cycle pulse requesting a clear of all RAM locations.
- clr_busy  output  1  clear pending or in progress.
- ram_addr  output  ADDR_WIDTH  drives the RAM addr.
- ram_data_in  output  DATA_WIDTH  drives the RAM data_in.
- ram_rdn_wr  output  1  drives the RAM rdn_wr; 1 = write, 0 = read.
- ram_data_out  input  DATA_WIDTH  RAM data_out.

Behaviour:
- RAM contract:
  - RAM samples addr, rdn_wr and data_in at a posedge.
  - A write commits at that edge.
  - Read data appears on ram_data_out after that edge and is stable for the following cycle.
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, clr_busy=0.
  - ram_addr=0, ram_data_in=0, ram_rdn_wr=0.
  - Clear pending flag and clear counter reset to 0.
  - A write in flight is aborted: ram_rdn_wr drops immediately.
- All RAM-side outputs and rsp_* outputs are registered.
- FSM states: IDLE, ACCESS, CAPTURE, CLEAR.
- Request acceptance:
  - req_ready = rst_n & (state==IDLE) & !rsp_valid & !clr_pending & !clr_start.
  - req_ready must not depend on req_valid.
- Accept edge E0 (req_valid & req_ready):
  - State -> ACCESS.
  - ram_addr <= req_addr, ram_rdn_wr <= req_wr, ram_data_in <= req_wdata (0 for reads).
- ACCESS (edge E1):
  - The RAM performs the operation.
  - ram_rdn_wr <= 0.
  - Write: state -> IDLE. Read: state -> CAPTURE.
- CAPTURE (edge E2): rsp_rdata <= ram_data_out, rsp_valid <= 1, state -> IDLE.
- Latency: read data valid 2 cycles after acceptance; max write throughput 1 per 2 cycles.
- Response channel:
  - rsp_valid and rsp_rdata hold stable until rsp_valid & rsp_ready.
  - At that edge rsp_valid <= 0.
  - No new request is accepted while rsp_valid=1, so at most one read is outstanding.
- Clear sequencing:
  - clr_start sets a sticky clr_pending in any state.
  - clr_pending is serviced when state==IDLE & !rsp_valid.
  - clr_start has priority over a simultaneous req_valid.
  - Entering CLEAR: counter=0, ram_rdn_wr=1, ram_data_in=0, ram_addr=counter.
  - The counter increments each cycle, one location per cycle.
  - After address 2**ADDR_WIDTH-1 is presented: ram_rdn_wr <= 0, state -> IDLE, clr_pending <= 0.
  - The counter is ADDR_WIDTH+1 bits wide so terminal detection does not wrap.
  - clr_start pulses during CLEAR are ignored; no re-trigger.
  - clr_busy = clr_pending | (state==CLEAR).
  - A clear lasts exactly 2**ADDR_WIDTH cycles of ram_rdn_wr=1.
- Idle RAM outputs: ram_rdn_wr=0, and ram_addr holds its last value.

Test Plan:
- Reset: assert rst_n=0 mid-write (ACCESS state, ram_rdn_wr=1) -> ram_rdn_wr, req_ready, rsp_valid and clr_busy go 0 immediately; after release, req_ready=1 the next cycle.
- Write then read: write 0xA5 to addr 0x1234, then read 0x1234 -> ram_rdn_wr=1 for exactly one cycle with ram_addr=0x1234; rsp_valid rises 2 cycles after read acceptance with rsp_rdata=0xA5.
- Response backpressure: hold rsp_ready=0 for 5 cycles after a read of 0x3C -> rsp_valid and rsp_rdata=0x3C stay stable, req_ready=0 throughout; one cycle with rsp_ready=1 -> rsp_valid=0 and req_ready=1.
- Back-to-back writes: req_valid held high with 4 writes to addr 0..3 -> accepted on alternating cycles; RAM sees addr 0,1,2,3 with data matching.
- Clear with ADDR_WIDTH=4:
  - Pre-write 0xFF to all 16 locations, pulse clr_start -> clr_busy=1, ram_addr 0..15 with ram_rdn_wr=1 and ram_data_in=0 for exactly 16 cycles, then clr_busy=0.
  - Reads of addr 0, 7 and 15 then return 0x00.
- Simultaneous events: clr_start while a read response is pending and req_valid=1 -> the read response completes first, the clear runs next, and the queued request is accepted only after clr_busy=0.
